// File: rtl/weight_feeder_if.sv
// Weight feeder bus bundle: load control, weight memory read port and the
// weight stream into the top PE of a systolic column.
// master = load requester / memory side, slave = the feeder itself.
interface weight_feeder_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 8
);
    localparam int NW = $clog2(DEPTH) + 1;

    logic             start;
    logic [AW-1:0]    base_addr;
    logic [NW-1:0]    num_rows;
    logic             mem_rd_en;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0] win;
    logic             wwrite;
    logic             busy;
    logic             done;

    modport master (
        output start, base_addr, num_rows, mem_rdata,
        input  mem_rd_en, mem_addr, win, wwrite, busy, done
    );

    modport slave (
        input  start, base_addr, num_rows, mem_rdata,
        output mem_rd_en, mem_addr, win, wwrite, busy, done
    );
endinterface

// File: rtl/weight_feeder.sv
// Weight feeder: reads n = min(num_rows, DEPTH) weights from memory, last row
// first, and shifts them into the top PE of a column so that the deepest PE
// ends up holding row n-1. All outputs are registered.
// Build option WFEED_ZERO_PAD_EN: every load pushes exactly DEPTH weights, the
// first DEPTH-n being zeros that need no memory read.
// The module parameters must match those of the connected interface.
module weight_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    weight_feeder_if.slave  bus
);
    localparam int NW = $clog2(DEPTH) + 1;
    localparam logic [NW-1:0] ONE_N   = NW'(1'b1);
    localparam logic [AW-1:0] ONE_A   = AW'(1'b1);
    localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // A "slot" is one cycle of the fetch phase that will become one wwrite
    // two cycles later (read, then memory latency, then output register).
    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;           // next address to read
    logic [NW-1:0]    slot_rem_q, slot_rem_d; // slots still to issue after current
    logic             slot_q, slot_d;         // slot issued this cycle
    logic             s2_v_q, s2_v_d;         // slot whose data is on mem_rdata
    logic             mem_rd_en_q, mem_rd_en_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] win_q, win_d;
    logic             wwrite_q, wwrite_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef WFEED_ZERO_PAD_EN
    logic [NW-1:0]    pad_rem_q, pad_rem_d;   // zero slots still to issue
    logic             slot_pad_q, slot_pad_d;
    logic             s2_pad_q, s2_pad_d;
    logic [NW-1:0]    pad_s;
`endif

    logic [NW-1:0]    n_s;
    logic [NW-1:0]    tot_s;
    logic [AW-1:0]    ptr_s;
    logic             issue_s;

    // Next-state, slot issue and output computation.
    always_comb begin
        state_d     = state_q;
        slot_d      = 1'b0;
        slot_rem_d  = slot_rem_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = {AW{1'b0}};
        s2_v_d      = slot_q;
        wwrite_d    = s2_v_q;
        issue_s     = 1'b0;
        tot_s       = slot_rem_q;
        ptr_s       = ptr_q;
        if (bus.num_rows > DEPTH_N) begin
            n_s = DEPTH_N;
        end else begin
            n_s = bus.num_rows;
        end
`ifdef WFEED_ZERO_PAD_EN
        pad_s      = pad_rem_q;
        slot_pad_d = 1'b0;
        s2_pad_d   = slot_pad_q;
        if (s2_v_q && !s2_pad_q) begin
            win_d = bus.mem_rdata;
        end else begin
            win_d = {WIDTH{1'b0}};
        end
`else
        if (s2_v_q) begin
            win_d = bus.mem_rdata;
        end else begin
            win_d = {WIDTH{1'b0}};
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
`ifdef WFEED_ZERO_PAD_EN
                    tot_s = DEPTH_N;
                    pad_s = DEPTH_N - n_s;
`else
                    tot_s = n_s;
`endif
                    ptr_s = bus.base_addr + AW'(n_s) - ONE_A;
                    if (tot_s == {NW{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        issue_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (slot_rem_q == {NW{1'b0}}) begin
                    state_d = S_DRAIN;
                end else begin
                    issue_s = 1'b1;
                end
            end
            S_DRAIN: begin
                // Last slot's data has been registered once nothing is in flight.
                if (!s2_v_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ptr_d = ptr_s;
`ifdef WFEED_ZERO_PAD_EN
        pad_rem_d = pad_s;
`endif
        if (issue_s) begin
            slot_d     = 1'b1;
            slot_rem_d = tot_s - ONE_N;
`ifdef WFEED_ZERO_PAD_EN
            if (pad_s != {NW{1'b0}}) begin
                slot_pad_d = 1'b1;
                pad_rem_d  = pad_s - ONE_N;
            end else begin
                mem_rd_en_d = 1'b1;
                mem_addr_d  = ptr_s;
                ptr_d       = ptr_s - ONE_A;
            end
`else
            mem_rd_en_d = 1'b1;
            mem_addr_d  = ptr_s;
            ptr_d       = ptr_s - ONE_A;
`endif
        end else begin
            slot_rem_d = slot_rem_q;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= {AW{1'b0}};
            slot_rem_q  <= {NW{1'b0}};
            slot_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            win_q       <= {WIDTH{1'b0}};
            wwrite_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef WFEED_ZERO_PAD_EN
            pad_rem_q   <= {NW{1'b0}};
            slot_pad_q  <= 1'b0;
            s2_pad_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            slot_rem_q  <= slot_rem_d;
            slot_q      <= slot_d;
            s2_v_q      <= s2_v_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            win_q       <= win_d;
            wwrite_q    <= wwrite_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef WFEED_ZERO_PAD_EN
            pad_rem_q   <= pad_rem_d;
            slot_pad_q  <= slot_pad_d;
            s2_pad_q    <= s2_pad_d;
`endif
        end
    end

    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.win       = win_q;
    assign bus.wwrite    = wwrite_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_weight_feeder.sv
// Bench for weight_feeder: directed loads plus randomized start/reset traffic.
// A reference model turns every accepted load into expected (cycle, value)
// events for reads, weight pushes and done; a negedge monitor pops and compares.
module tb_weight_feeder;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 8;
    localparam int NW    = $clog2(DEPTH) + 1;
    localparam int AMASK = (1 << AW) - 1;

    typedef struct { int c; int v; } ev_t;

    logic clk;
    logic rst_n;
    weight_feeder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) bus ();

    weight_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;
    int   busy_lo = 0;
    int   busy_hi = -1;
    ev_t  evq [3][$];
    string kname [3] = '{"rd_addr", "win", "done"};
    logic [WIDTH-1:0] mem [1 << AW];
    bit   pend_en = 1'b0;
    int   pend_a = 0;
    bit   mon_s [3];
    int   mon_a [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory with one cycle of read latency; unread cycles carry junk.
    always @(negedge clk) begin
        pend_en = (bus.mem_rd_en === 1'b1);
        pend_a  = int'(bus.mem_addr);
    end
    always @(posedge clk) begin
        #1;
        if (pend_en) bus.mem_rdata = mem[pend_a];
        else         bus.mem_rdata = WIDTH'($urandom);
    end

    // Reference model of one accepted load starting in cycle c0.
    task automatic model_load(input int c0, input int b, input int r);
        int n, p, tot, a, dc;
        ev_t e;
        n = (r > DEPTH) ? DEPTH : r;
`ifdef WFEED_ZERO_PAD_EN
        p   = DEPTH - n;
        tot = DEPTH;
        for (int j = 0; j < p; j++) begin
            e.c = c0 + 3 + j; e.v = 0; evq[1].push_back(e);
        end
`else
        p   = 0;
        tot = n;
`endif
        for (int i = 0; i < n; i++) begin
            a = (b + n - 1 - i) & AMASK;
            e.c = c0 + 1 + p + i; e.v = a;      evq[0].push_back(e);
            e.c = c0 + 3 + p + i; e.v = mem[a]; evq[1].push_back(e);
        end
        dc = (tot == 0) ? c0 + 1 : c0 + tot + 3;
        e.c = dc; e.v = 1; evq[2].push_back(e);
        busy_lo = c0 + 1;
        busy_hi = dc;
    endtask

    // Reset sampled at the end of cycle c cancels everything after it.
    task automatic flush(input int c);
        for (int k = 0; k < 3; k++)
            for (int i = evq[k].size() - 1; i >= 0; i--)
                if (evq[k][i].c > c) evq[k].delete(i);
        if (busy_hi > c) busy_hi = c;
    endtask

    // Drive one cycle of inputs and let the model decide acceptance.
    task automatic drive_cycle(input bit st, input int b, input int r, input bit rn);
        @(posedge clk);
        #2;
        bus.start     = st;
        bus.base_addr = AW'(b);
        bus.num_rows  = NW'(r);
        rst_n         = rn;
        if (!rn)                       flush(cyc);
        else if (st && cyc > busy_hi)  model_load(cyc, b & AMASK, r);
    endtask

    task automatic wait_idle();
        while (cyc <= busy_hi) drive_cycle(1'b0, 0, 0, 1'b1);
        drive_cycle(1'b0, 0, 0, 1'b1);
    endtask

    // Monitor: pop expected events when the DUT presents them.
    always @(negedge clk) begin
        if (chk_en) begin
            ev_t e;
            mon_s[0] = bus.mem_rd_en; mon_a[0] = int'(bus.mem_addr);
            mon_s[1] = bus.wwrite;    mon_a[1] = int'(bus.win);
            mon_s[2] = bus.done;      mon_a[2] = 1;
            for (int k = 0; k < 3; k++) begin
                while (evq[k].size() > 0 && evq[k][0].c < cyc) begin
                    chk({kname[k], "_missing"}, 0, 1);
                    void'(evq[k].pop_front());
                end
                if (mon_s[k]) begin
                    if (evq[k].size() == 0 || evq[k][0].c != cyc) begin
                        chk({kname[k], "_unexpected"}, 1, 0);
                    end else begin
                        e = evq[k].pop_front();
                        chk(kname[k], mon_a[k], e.v);
                    end
                end
            end
            chk("busy", int'(bus.busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            if (!bus.wwrite) chk("win_idle_zero", int'(bus.win), 0);
        end
    end

    initial begin
        bit st, rn;
        int b, r;
        for (int i = 0; i < (1 << AW); i++) mem[i] = WIDTH'(4 * i);
        rst_n = 1'b0; bus.start = 1'b1; bus.base_addr = '0; bus.num_rows = '0;

        // Reset held two cycles with start high.
        drive_cycle(1'b1, 0, 4, 1'b0);
        drive_cycle(1'b1, 0, 4, 1'b0);
        chk("rst_mem_rd_en", int'(bus.mem_rd_en), 0);
        chk("rst_mem_addr",  int'(bus.mem_addr),  0);
        chk("rst_win",       int'(bus.win),       0);
        chk("rst_wwrite",    int'(bus.wwrite),    0);
        chk("rst_busy",      int'(bus.busy),      0);
        chk("rst_done",      int'(bus.done),      0);
        chk_en = 1'b1;
        drive_cycle(1'b0, 0, 0, 1'b1);
        drive_cycle(1'b0, 0, 0, 1'b1);

        // Directed loads: normal, empty, oversized, address wrap.
        drive_cycle(1'b1, 0, 4, 1'b1);   wait_idle();
        drive_cycle(1'b1, 5, 0, 1'b1);   wait_idle();
        drive_cycle(1'b1, 40, 20, 1'b1); wait_idle();
        drive_cycle(1'b1, 254, 4, 1'b1); wait_idle();

        // Start again in cycle 2 and in the DONE cycle: both ignored.
        drive_cycle(1'b1, 8, 4, 1'b1);
        drive_cycle(1'b0, 0, 0, 1'b1);
        drive_cycle(1'b1, 100, 7, 1'b1);
        while (cyc < busy_hi) drive_cycle(1'b0, 0, 0, 1'b1);
        drive_cycle(1'b1, 60, 3, 1'b1);
        wait_idle();

        // Reset in cycle 4 of a load aborts it.
        drive_cycle(1'b1, 20, 6, 1'b1);
        repeat (3) drive_cycle(1'b0, 0, 0, 1'b1);
        drive_cycle(1'b0, 0, 0, 1'b0);
        wait_idle();

        // Randomized traffic over random memory contents.
        for (int i = 0; i < (1 << AW); i++) mem[i] = WIDTH'($urandom);
        for (int i = 0; i < 600; i++) begin
            st = ($urandom_range(3) == 0);
            rn = ($urandom_range(49) != 0);
            b  = int'($urandom_range(AMASK));
            r  = int'($urandom_range(20));
            drive_cycle(st, b, r, rn);
        end
        wait_idle();
        repeat (3) drive_cycle(1'b0, 0, 0, 1'b1);
        for (int k = 0; k < 3; k++) chk({kname[k], "_leftover"}, evq[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
